alu_sra: RTL and testbench



---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_sra_stage.sv | 20 ++
 rtl/alu_sra.sv | 99 +++++++++
 tb/tb_alu_sra.sv | 129 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU package: datapath width, shift-amount width and common types.
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = $clog2(XLEN);

  typedef logic [XLEN-1:0]    word_t;
  typedef logic [SHAMT_W-1:0] shamt_t;

  // Barrel-shifter stage after which the optional pipeline register sits.
  localparam int SRA_PIPE_STAGE = 2;
  localparam int SRA_HI_W       = SHAMT_W - SRA_PIPE_STAGE - 1;

endpackage

// File: rtl/alu_sra_stage.sv
// One barrel-shifter stage: arithmetic shift right by 2**K when enabled.
module alu_sra_stage
  import alu_pkg::*;
#(
  parameter int K = 0
) (
  input  word_t data,
  input  logic  sign,
  input  logic  enable,
  output word_t result
);

  localparam int SH = 1 << K;

  word_t shifted;

  assign shifted = {{SH{sign}}, data[XLEN-1:SH]};
  assign result  = enable ? shifted : data;

endmodule

// File: rtl/alu_sra.sv
// Arithmetic shift right (rd = rs1 >>> rs2[4:0]) with registered result.
// Optional ALU_SRA_PIPE_EN adds a register after stage 2 (latency 2).
module alu_sra
  import alu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  input  word_t rs1,
  input  word_t rs2,
  output word_t rd,
  output logic  out_valid
);

  shamt_t shamt;
  logic   unused_rs2_hi;

  assign shamt         = rs2[SHAMT_W-1:0];
  assign unused_rs2_hi = ^rs2[XLEN-1:SHAMT_W];

  // Everything the upper stages need, taken either straight through or
  // from the mid-pipeline register.
  word_t               mid_data;
  logic                mid_sign;
  logic [SRA_HI_W-1:0] mid_shamt;
  logic                mid_valid;

  for (genvar gi = 0; gi < SHAMT_W; gi++) begin : gen_stage
    word_t din;
    word_t dout;
    logic  sgn;
    logic  en;

    if (gi == 0) begin : g_first
      assign din = rs1;
    end else if (gi == SRA_PIPE_STAGE + 1) begin : g_mid
      assign din = mid_data;
    end else begin : g_chain
      assign din = gen_stage[gi-1].dout;
    end

    if (gi <= SRA_PIPE_STAGE) begin : g_lo
      assign sgn = rs1[XLEN-1];
      assign en  = shamt[gi];
    end else begin : g_hi
      assign sgn = mid_sign;
      assign en  = mid_shamt[gi-SRA_PIPE_STAGE-1];
    end

    alu_sra_stage #(.K(gi)) u_stage (
      .data   (din),
      .sign   (sgn),
      .enable (en),
      .result (dout)
    );
  end

`ifdef ALU_SRA_PIPE_EN
  word_t               mid_data_reg;
  logic                mid_sign_reg;
  logic [SRA_HI_W-1:0] mid_shamt_reg;
  logic                mid_valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      mid_data_reg  <= '0;
      mid_sign_reg  <= 1'b0;
      mid_shamt_reg <= '0;
      mid_valid_reg <= 1'b0;
    end else begin
      mid_data_reg  <= gen_stage[SRA_PIPE_STAGE].dout;
      mid_sign_reg  <= rs1[XLEN-1];
      mid_shamt_reg <= shamt[SHAMT_W-1:SRA_PIPE_STAGE+1];
      mid_valid_reg <= in_valid;
    end
  end

  assign mid_data  = mid_data_reg;
  assign mid_sign  = mid_sign_reg;
  assign mid_shamt = mid_shamt_reg;
  assign mid_valid = mid_valid_reg;
`else
  assign mid_data  = gen_stage[SRA_PIPE_STAGE].dout;
  assign mid_sign  = rs1[XLEN-1];
  assign mid_shamt = shamt[SHAMT_W-1:SRA_PIPE_STAGE+1];
  assign mid_valid = in_valid;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rd        <= '0;
      out_valid <= 1'b0;
    end else begin
      rd        <= gen_stage[SHAMT_W-1].dout;
      out_valid <= mid_valid;
    end
  end

endmodule

// File: tb/tb_alu_sra.sv
// Directed-vector bench for alu_sra; latency follows ALU_SRA_PIPE_EN.
module tb_alu_sra;

`ifdef ALU_SRA_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NVEC = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] rd;
  logic        out_valid;

  int n_cmp = 0;
  int n_bad = 0;

  // Hand-computed vectors: {rs1, rs2, expected rd}
  logic [31:0] vec_rs1 [NVEC] = '{
    32'h0000_0002, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000,
    32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678,
    32'h1234_5678, 32'h8000_0000, 32'hF000_0000, 32'h4000_0000,
    32'h8765_4321, 32'h8765_4321, 32'h5555_5555, 32'hAAAA_AAAA};
  logic [31:0] vec_rs2 [NVEC] = '{
    32'd1,  32'd31, 32'd1,  32'd31,
    32'd4,  32'd1,  32'd32, 32'hFFFF_FFE4,
    32'd0,  32'd1,  32'd16, 32'd30,
    32'd8,  32'd33, 32'd2,  32'd3};
  logic [31:0] vec_exp [NVEC] = '{
    32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
    32'hF800_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0123_4567,
    32'h1234_5678, 32'hC000_0000, 32'hFFFF_F000, 32'h0000_0001,
    32'hFF87_6543, 32'hC3B2_A190, 32'h1555_5555, 32'hF555_5555};

  alu_sra dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives slots 0..count-1 one per cycle (vector base+slot, valid per mask)
  // and checks each output exactly LAT cycles later. Sampling and driving
  // both happen on the falling edge.
  task automatic run_slots(input int base, input int count, input logic [31:0] mask);
    int idx;
    for (int cyc = 0; cyc < count + LAT; cyc++) begin
      @(negedge clk);
      if (cyc >= LAT) begin
        idx = cyc - LAT;
        check($sformatf("valid[%0d]", base + idx), {31'd0, out_valid}, {31'd0, mask[idx]});
        if (mask[idx]) begin
          check($sformatf("rd[%0d]", base + idx), rd, vec_exp[(base + idx) % NVEC]);
          $display("op %0d: rs1=%h rs2=%h -> rd=%h", base + idx,
                   vec_rs1[(base + idx) % NVEC], vec_rs2[(base + idx) % NVEC], rd);
        end
      end
      if (cyc < count) begin
        in_valid = mask[cyc];
        rs1      = mask[cyc] ? vec_rs1[(base + cyc) % NVEC] : 32'hDEAD_BEEF;
        rs2      = mask[cyc] ? vec_rs2[(base + cyc) % NVEC] : 32'd7;
      end else begin
        in_valid = 1'b0;
        rs1      = 32'h0;
        rs2      = 32'h0;
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    rs1      = 32'h8000_0000;
    rs2      = 32'd1;

    // Reset overrides in_valid.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_rd", rd, 32'h0);
      check("reset_valid", {31'd0, out_valid}, 32'd0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;

    // Toggling valid: every vector, with gaps between them.
    run_slots(0, 16, 32'b0101_1011_0110_1101);
    run_slots(0, 16, 32'b1010_0100_1001_0010);
    // Back-to-back, 8 consecutive valid operations.
    run_slots(4, 8, 32'hFF);

    // Reset while an operation is in flight discards it.
    @(negedge clk);
    in_valid = 1'b1;
    rs1      = 32'h8000_0000;
    rs2      = 32'd4;
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("flight_rd", rd, 32'h0);
    check("flight_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_flight_valid", {31'd0, out_valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
